// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over shared hi/lo registers, with valid/ready request and response ports.
module muldiv_unit #(
  parameter int Width    = 32,
  parameter int TagWidth = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [Width-1:0]    a,
  input  logic [Width-1:0]    b,
  input  logic [TagWidth-1:0] tag,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [Width-1:0]    res,
  output logic [TagWidth-1:0] out_tag
);

  // Handshake: a request transfers on an edge where in_valid && in_ready && !flush;
  // a response transfers on an edge where out_valid && out_ready; flush wins over both.

  localparam int CntW = $clog2(Width) + 1;
  localparam logic [CntW-1:0]  LastIter = CntW'(Width - 1);
  localparam logic [Width-1:0] MinNeg   = {1'b1, {(Width-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [CntW-1:0]  cnt;
  logic [2:0]       op_q;
  logic             neg_q;
  logic             special_q;
  logic [Width-1:0] hi;
  logic [Width-1:0] lo;
  logic [Width-1:0] dsr;

  // Request decode
  logic             accept;
  logic             is_div;
  logic             is_rem;
  logic             signed_a;
  logic             signed_b;
  logic             neg_a;
  logic             neg_b;
  logic [Width-1:0] mag_a;
  logic [Width-1:0] mag_b;
  logic             div_zero;
  logic             div_ovf;
  logic             special;
  logic [Width-1:0] special_val;
  logic             neg_res;

  always_comb begin
    accept   = in_valid && in_ready && !flush;
    is_div   = op[2];
    is_rem   = op[2] && op[1];
    signed_a = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    signed_b = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    neg_a    = signed_a && a[Width-1];
    neg_b    = signed_b && b[Width-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && !op[0] && (a == MinNeg) && (b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_val = is_rem ? a : '1;
    end else begin
      special_val = is_rem ? '0 : a;
    end
    // Remainder takes the dividend's sign; quotient and products take the XOR.
    neg_res = is_rem ? neg_a : (neg_a ^ neg_b);
  end

  // One iteration step for each algorithm
  logic             mul_carry;
  logic [Width-1:0] mul_sum;
  logic [Width-1:0] mul_hi_next;
  logic [Width-1:0] mul_lo_next;
  logic [Width:0]   div_trial;
  logic [Width-1:0] div_hi_next;
  logic [Width-1:0] div_lo_next;

  always_comb begin
    {mul_carry, mul_sum} = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
    mul_hi_next          = {mul_carry, mul_sum[Width-1:1]};
    mul_lo_next          = {mul_sum[0], lo[Width-1:1]};

    // hi < dsr always holds, so bit Width of the trial is exactly the borrow.
    div_trial   = {hi, lo[Width-1]} - {1'b0, dsr};
    div_hi_next = div_trial[Width] ? {hi[Width-2:0], lo[Width-1]} : div_trial[Width-1:0];
    div_lo_next = {lo[Width-2:0], ~div_trial[Width]};
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) state_next = special ? DONE : BUSY;
        BUSY: if (cnt == LastIter) state_next = DONE;
        DONE: if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      dsr       <= '0;
      out_tag   <= '0;
    end else if (accept) begin
      cnt       <= '0;
      op_q      <= op;
      neg_q     <= neg_res && !special;
      special_q <= special;
      hi        <= '0;
      lo        <= special ? special_val : mag_a;
      dsr       <= mag_b;
      out_tag   <= tag;
    end else if (state == BUSY && !flush) begin
      cnt <= cnt + CntW'(1);
      if (op_q[2]) begin
        hi <= div_hi_next;
        lo <= div_lo_next;
      end else begin
        hi <= mul_hi_next;
        lo <= mul_lo_next;
      end
    end
  end

  // Result path: sign correction of the magnitude result happens here.
  logic [2*Width-1:0] prod_mag;
  logic [2*Width-1:0] prod_signed;
  logic [Width-1:0]   div_sel;
  logic [Width-1:0]   div_signed;

  always_comb begin
    prod_mag    = {hi, lo};
    prod_signed = neg_q ? -prod_mag : prod_mag;
    div_sel     = op_q[1] ? hi : lo;
    div_signed  = neg_q ? -div_sel : div_sel;
    if (special_q) begin
      res = lo;
    end else if (op_q[2]) begin
      res = div_signed;
    end else if (op_q == 3'd0) begin
      res = prod_signed[Width-1:0];
    end else begin
      res = prod_signed[2*Width-1:Width];
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks for muldiv_unit: results, latency, backpressure,
// flush and asynchronous reset, with a scoreboard queue of expected {tag, result}.
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [TW-1:0] tag = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  res;
  logic [TW-1:0] out_tag;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  logic [TW+W-1:0] exp_q[$];

  muldiv_unit #(.Width(W), .TagWidth(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .tag(tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .out_tag(out_tag)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model built on native signed/unsigned arithmetic
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy, uy, sp;
    logic [2*W-1:0]        up;
    logic signed [W-1:0]   qx, qy;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    uy = {{W{1'b0}}, y};
    up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    qx = x;
    qy = y;
    case (o)
      3'd0: return up[W-1:0];
      3'd1: begin sp = sx * sy; return sp[2*W-1:W]; end
      3'd2: begin sp = sx * uy; return sp[2*W-1:W]; end
      3'd3: return up[2*W-1:W];
      3'd4: begin
        if (y == '0) return '1;
        if (x == MIN && y == '1) return x;
        return qx / qy;
      end
      3'd5: return (y == '0) ? '1 : x / y;
      3'd6: begin
        if (y == '0) return x;
        if (x == MIN && y == '1) return '0;
        return qx % qy;
      end
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [W-1:0] x,
                                    input logic [W-1:0] y);
    return o[2] && ((y == '0) || (!o[0] && x == MIN && y == '1));
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Driver: called at a negedge, returns just after the accept edge.
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [TW-1:0] t, input logic [W-1:0] e);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", 64'(in_ready), 64'(1));
    op = o; a = x; b = y; tag = t; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back({t, e});
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom_range(0, 7));
    tag = TW'($urandom_range(0, 31));
  endtask

  // Waits for out_valid; cyc counts cycles after the accept cycle.
  task automatic wait_out(output int cyc);
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic collect(input int exp_lat);
    int cyc;
    logic [TW+W-1:0] e;
    wait_out(cyc);
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("sb_depth", 64'(exp_q.size()), 64'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("res", 64'(res), 64'(e[W-1:0]));
      chk("out_tag", 64'(out_tag), 64'(e[TW+W-1:W]));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_after_take", 64'(in_ready), 64'(1));
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [TW-1:0] t, input logic [W-1:0] e);
    send(o, x, y, t, e);
    collect(is_special(o, x, y) ? 1 : W + 1);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(name, 64'(seen), 64'(0));
  endtask

  initial begin
    int cyc;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_res", 64'(res), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic
    run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'h11, 32'hFFFF_FFEB);
    run(3'd1, MIN, MIN, 5'h01, 32'h4000_0000);
    run(3'd3, MIN, MIN, 5'h02, 32'h4000_0000);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 32'hFFFF_FFFF);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'h04, 32'hFFFF_FFFD);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'h05, 32'hFFFF_FFFF);
    run(3'd5, 32'd100, 32'd7, 5'h06, 32'd14);
    run(3'd7, 32'd100, 32'd7, 5'h07, 32'd2);

    // Early-completing special cases
    run(3'd5, 32'h1234_5678, 32'd0, 5'h08, 32'hFFFF_FFFF);
    run(3'd6, 32'd5, 32'd0, 5'h09, 32'd5);
    run(3'd4, MIN, 32'hFFFF_FFFF, 5'h0A, MIN);
    run(3'd6, MIN, 32'hFFFF_FFFF, 5'h0B, 32'd0);

    // Random operations against the model
    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (i == 11) begin
        ro = 3'd4; ra = MIN; rb = 32'hFFFF_FFFF;
      end
      run(ro, ra, rb, TW'(i), model(ro, ra, rb));
    end

    // Backpressure: result held, no accept while DONE
    send(3'd5, 32'd100, 32'd7, 5'h13, 32'd14);
    wait_out(cyc);
    chk("bp_latency", 64'(cyc), 64'(W + 1));
    op = 3'd0; a = 32'd3; b = 32'd3; tag = 5'h1F; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_res", 64'(res), 64'(32'd14));
      chk("bp_out_tag", 64'(out_tag), 64'(5'h13));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", 64'(in_ready), 64'(1));
    chk("bp_release_out_valid", 64'(out_valid), 64'(0));
    void'(exp_q.pop_front());
    @(negedge clk);

    // Flush at iteration 10, with a competing request on the same edge
    send(3'd3, $urandom, $urandom, 5'h14, 32'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    op = 3'd5; a = 32'd9; b = 32'd0; tag = 5'h15; in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    exp_q.delete();
    watch_quiet("flush_no_response", 40);
    run(3'd1, 32'hFFFF_FFF9, 32'd6, 5'h16, model(3'd1, 32'hFFFF_FFF9, 32'd6));
    run(3'd0, 32'h0001_0003, 32'h0002_0005, 5'h17, 32'h000B_000F);

    // Asynchronous reset in the middle of BUSY
    send(3'd4, 32'hFFFF_FF00, 32'd3, 5'h18, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_res", 64'(res), 64'(0));
    chk("arst_out_tag", 64'(out_tag), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    watch_quiet("arst_no_response", 40);
    run(3'd6, 32'd1000, 32'hFFFF_FFF9, 5'h19, 32'd6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, multi-cycle integer multiply/divide unit implementing the eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) with valid/ready handshakes on both sides. Sits beside the single-cycle ALU in the execute stage. The pipeline issues an M-extension op, stalls on `in_ready`, and collects the result plus its destination tag. Computation is radix-2 iterative (one bit per cycle), and divide special cases complete early.

## Interface
- `Width`, 32: operand/result width; even, ≥ 4.
- `TagWidth`, 5: width of the opaque tag carried from request to response.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request.
- `op`  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a`, `b`  in  Width  rs1, rs2 operands.
- `tag`  in  TagWidth  destination tag.
- `flush`  in  1  abort any in-flight or pending operation.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `res`  out  Width  result.
- `out_tag`  out  TagWidth  tag of the accepted request.

## Operation
- States: IDLE, BUSY, DONE. `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- Accept: `in_valid && in_ready && !flush` at an edge. The edge latches `op` and `tag`, the operand magnitudes, the result-sign bits, and clears the iteration counter.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - DIV, REM: signed.
  - All others: unsigned.
- Sign handling: operands are converted to magnitudes at accept. Negation of the final result is applied on the output path.
- Multiply:
  - Shift-add over a 2·Width product register.
  - MUL returns the low Width bits. MULH, MULHSU and MULHU return the high Width bits of the correctly signed 2·Width product.
- Divide:
  - Restoring division; quotient and remainder registers are Width bits each.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Special cases are detected at accept. They go straight to DONE with no iterations:
  - Divide by zero (`b == 0`): DIV/DIVU return all-ones; REM/REMU return `a`.
  - Signed overflow (DIV/REM with `a` = most-negative and `b` = −1): DIV returns `a`; REM returns 0.
- BUSY runs exactly Width iterations. A counter of `$clog2(Width)+1` bits counts them; on terminal count the state moves to DONE.
- DONE:
  - `res`/`out_tag` stay stable while `out_valid && !out_ready`.
  - On `out_ready`, the state returns to IDLE.
  - There is no same-cycle re-accept; the next request is accepted no earlier than the following edge.
- Flush: at any edge with `flush` = 1, the state goes to IDLE, `out_valid` drops, and any concurrent `in_valid` is ignored. Flush has priority over acceptance and completion.

## Timing
- Reset (async assert) values:
  - State IDLE, `in_ready` = 1, `out_valid` = 0.
  - `res` = 0, `out_tag` = 0, counter = 0, datapath registers = 0.
- Reset deasserted mid-operation: the unit resumes from IDLE; the aborted operation produces no response.
- Normal-op latency: the accept edge is edge 0. Iterations happen on edges 1..Width. `out_valid` is high in the cycle after edge Width, so the result appears Width+1 cycles after `in_valid` was sampled.
- Special-case latency: `out_valid` is high in the cycle after the accept edge.
- Throughput: one operation per Width+2 cycles when `out_ready` is held high.
- `in_ready` is registered state, not combinationally dependent on `in_valid`. `out_valid` does not depend on `out_ready`.
- Inputs `a`, `b`, `op` and `tag` are don't-care after the accept edge.

## Test plan
- MUL, `a`=7, `b`=0xFFFFFFFD (−3), Width=32 → `res`=0xFFFFFFEB; `out_valid` rises exactly 33 cycles after the accept cycle; `out_tag` echoes the input.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU same operands → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases with 1-cycle latency:
  - DIVU x/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold `out_ready`=0 for 10 cycles after completion. `res`/`out_tag` stay constant, `in_ready`=0, and a new `in_valid` is not accepted. Raise `out_ready` → IDLE next edge.
- Abort:
  - `flush` pulse at iteration 10 → IDLE next edge, no `out_valid`, and the next request completes correctly.
  - Repeat with a `rst` pulse mid-BUSY → all outputs at reset values immediately (asynchronous).
